// File: rtl/map_pkg.sv
// map_pkg: playfield geometry, tile codes and blast direction types
package map_pkg;
  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int MAP_TILES = MAP_W * MAP_H;
  typedef logic [8:0] tile_idx_t;
  typedef enum logic [2:0] {
    T_EMPTY = 3'd0,
    T_WALL  = 3'd1,
    T_BRICK = 3'd2,
    T_BASE0 = 3'd3,
    T_BASE1 = 3'd4
  } tile_e;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; ports: clk_i, rst_ni, req_i, adv_i (commit grant), gnt_o
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= 1'b1;
    else if (adv_i && |req_i) last_q <= gnt_o[1];
endmodule

// File: rtl/blast_scheduler.sv
// blast_scheduler: serialises two players' blast requests into cross-pattern probes/clears of the tile map; ports: req/ack handshake per player, err/base_hit/busy status, map read (rd_idx_o/rd_data_i) and write (wr_*) ports
module blast_scheduler
  import map_pkg::*;
#(
  parameter int RADIUS = 2,
  parameter int IDX_W  = 9,
  parameter int TILE_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [IDX_W-1:0]  req_idx0_i,
  input  logic [IDX_W-1:0]  req_idx1_i,
  output logic [1:0]        ack_o,
  output logic [3:0]        cleared_cnt_o,
  output logic              err_o,
  output logic [1:0]        base_hit_o,
  output logic              busy_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  input  logic [TILE_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output logic [TILE_W-1:0] wr_data_o
);
  typedef enum logic [2:0] {S_IDLE, S_CENTER, S_PROBE, S_WRITE, S_DONE} state_e;
  state_e state_q, state_d;
  dir_e dir_q, dir_d;
  logic [2:0] dist_q, dist_d;
  logic [3:0] row_q, row_d, cnt_q, cnt_d;
  logic [4:0] col_q, col_d;
  logic [1:0] gnt_q, gnt_d, base_q, base_d, gnt;
  logic err_q, err_d, adv, inb, fin;
  logic [IDX_W-1:0] rd_idx_q, sel_idx, probe_idx;
  logic signed [6:0] dd, tr, tc;
  rr_arb2 u_arb (.clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .adv_i(adv), .gnt_o(gnt));
  // dist 0 addresses the centre, so CENTER and PROBE share one address path
  assign dd = 7'(dist_q);
  assign tr = 7'(row_q) + (dir_q == D_UP ? -dd : dir_q == D_DOWN ? dd : 7'sd0);
  assign tc = 7'(col_q) + (dir_q == D_LEFT ? -dd : dir_q == D_RIGHT ? dd : 7'sd0);
  assign inb = !tr[6] && !tc[6] && tr[5:0] < 6'(MAP_H) && tc[5:0] < 6'(MAP_W);
  assign probe_idx = IDX_W'(32'(tr[5:0]) * MAP_W + 32'(tc[5:0]));
  assign sel_idx = gnt[1] ? req_idx1_i : req_idx0_i;
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dist_d  = dist_q;
    row_d   = row_q;
    col_d   = col_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    base_d  = 2'b00;
    adv     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: if (|req_i) begin
        adv     = 1'b1;
        gnt_d   = gnt;
        row_d   = 4'(32'(sel_idx) / MAP_W);
        col_d   = 5'(32'(sel_idx) % MAP_W);
        cnt_d   = '0;
        dir_d   = D_UP;
        dist_d  = '0;
        err_d   = 32'(sel_idx) >= MAP_TILES;
        state_d = err_d ? S_DONE : S_CENTER;
      end
      S_CENTER: begin
        base_d  = {rd_data_i == TILE_W'(T_BASE1), rd_data_i == TILE_W'(T_BASE0)};
        state_d = rd_data_i == TILE_W'(T_BRICK) ? S_WRITE : S_PROBE;
        dist_d  = rd_data_i == TILE_W'(T_BRICK) ? dist_q : 3'd1;
      end
      S_PROBE: begin
        base_d  = inb ? {rd_data_i == TILE_W'(T_BASE1), rd_data_i == TILE_W'(T_BASE0)} : 2'b00;
        state_d = inb && rd_data_i == TILE_W'(T_BRICK) ? S_WRITE : S_PROBE;
        dist_d  = dist_q + 3'd1;
        fin     = !inb || (rd_data_i == TILE_W'(T_EMPTY) ? dist_q == 3'(RADIUS)
                                                        : rd_data_i != TILE_W'(T_BRICK));
      end
      S_WRITE: begin
        cnt_d   = cnt_q == 4'hf ? cnt_q : cnt_q + 4'd1;
        state_d = S_PROBE;
        dist_d  = 3'd1;
        fin     = dist_q != 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = dir_q == D_RIGHT ? S_DONE : S_PROBE;
      dir_d   = dir_e'(dir_q + 2'd1);
      dist_d  = 3'd1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      dir_q    <= D_UP;
      dist_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      base_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      dist_q   <= dist_d;
      row_q    <= row_d;
      col_q    <= col_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      rd_idx_q <= rd_idx_o;
    end
  // rd_idx_q holds the last probed index, which is also the brick being cleared in WRITE
  assign rd_idx_o      = state_q == S_CENTER || (state_q == S_PROBE && inb) ? probe_idx : rd_idx_q;
  assign wr_en_o       = state_q == S_WRITE;
  assign wr_idx_o      = rd_idx_q;
  assign wr_data_o     = '0;
  assign busy_o        = state_q != S_IDLE;
  assign ack_o         = state_q == S_DONE ? gnt_q : 2'b00;
  assign err_o         = state_q == S_DONE && err_q;
  assign base_hit_o    = base_q;
  assign cleared_cnt_o = cnt_q;
endmodule

// File: tb/tb_blast_scheduler.sv
// tb_blast_scheduler: directed checks of blast_scheduler against a behavioural tile map
module tb_blast_scheduler;
  logic clk, rst_n, err, busy, wr_en;
  logic [1:0] req, ack, base_hit;
  logic [8:0] req_idx0, req_idx1, rd_idx, wr_idx;
  logic [3:0] cleared_cnt;
  logic [2:0] rd_data, wr_data;
  logic [2:0] mem [0:299];
  int checks = 0, failures = 0;
  int rdlog [0:63];
  bit seen [0:511];
  int nwr, last_wi, wd_bad, bh0, bh1, ack_cyc, cnt, errv, wr_ack, nack;
  logic [1:0] acks [$];

  blast_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_idx0_i(req_idx0), .req_idx1_i(req_idx1),
    .ack_o(ack), .cleared_cnt_o(cleared_cnt), .err_o(err), .base_hit_o(base_hit), .busy_o(busy),
    .rd_idx_o(rd_idx), .rd_data_i(rd_data), .wr_en_o(wr_en), .wr_idx_o(wr_idx), .wr_data_o(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rd_data = rd_idx < 9'd300 ? mem[rd_idx] : 3'd1;
  always @(posedge clk) if (wr_en && wr_idx < 9'd300) mem[wr_idx] <= wr_data;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic init_map();
    for (int i = 0; i < 300; i++)
      mem[i] = (i / 20 == 0 || i / 20 == 14 || i % 20 == 0 || i % 20 == 19) ? 3'd1 : 3'd0;
  endtask

  // called at a negedge with the DUT idle; cycle k of the log is T+k
  task automatic run(input logic [1:0] r, input int i0, input int i1);
    req_idx0 = 9'(i0);
    req_idx1 = 9'(i1);
    req = r;
    nwr = 0; wd_bad = 0; bh0 = 0; bh1 = 0; ack_cyc = -1; cnt = -1; errv = -1; wr_ack = 0;
    acks.delete();
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    for (int k = 1; k <= 60 && req != 2'b00; k++) begin
      @(negedge clk);
      rdlog[k] = int'(rd_idx);
      if (busy) seen[rd_idx] = 1'b1;
      if (wr_en) begin
        nwr++;
        last_wi = int'(wr_idx);
        if (wr_data != 3'd0) wd_bad++;
      end
      bh0 += int'(base_hit[0]);
      bh1 += int'(base_hit[1]);
      if (ack != 2'b00) begin
        acks.push_back(ack);
        if (ack_cyc < 0) begin
          ack_cyc = k;
          cnt = int'(cleared_cnt);
          errv = int'(err);
        end
        if (wr_en) wr_ack++;
        req = req & ~ack;
      end
    end
    chk("op_completes", int'(req), 0);
    @(negedge clk);
  endtask

  initial begin
    int exp_rd [9] = '{105, 85, 65, 125, 145, 104, 103, 106, 107};
    rst_n = 1'b0;
    req = 2'b00;
    req_idx0 = '0;
    req_idx1 = '0;
    init_map();
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_idx", int'(rd_idx), 0);
    chk("rst_wr_idx", int'(wr_idx), 0);
    chk("rst_cnt", int'(cleared_cnt), 0);
    chk("rst_err_base", int'({err, base_hit}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b01, 105, 0);
    chk("open_ack_cycle", ack_cyc, 10);
    chk("open_ack_who", int'(acks[0]), 1);
    chk("open_writes", nwr, 0);
    chk("open_cnt", cnt, 0);
    chk("open_err", errv, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("open_rd[%0d]", i + 1), rdlog[i + 1], exp_rd[i]);

    init_map();
    mem[85] = 3'd2;
    run(2'b01, 105, 0);
    chk("brick_writes", nwr, 1);
    chk("brick_wr_idx", last_wi, 85);
    chk("brick_wr_data", wd_bad, 0);
    chk("brick_65_unread", int'(seen[65]), 0);
    chk("brick_cnt", cnt, 1);
    chk("brick_cleared", int'(mem[85]), 0);
    chk("brick_no_wr_ack", wr_ack, 0);

    init_map();
    mem[107] = 3'd2;
    run(2'b01, 105, 0);
    chk("last_brick_ack_cycle", ack_cyc, 11);
    chk("last_brick_cnt", cnt, 1);
    chk("last_brick_cleared", int'(mem[107]), 0);

    init_map();
    mem[105] = 3'd2;
    run(2'b01, 105, 0);
    chk("ctr_brick_ack_cycle", ack_cyc, 11);
    chk("ctr_brick_rd3", rdlog[3], 85);
    chk("ctr_brick_cnt", cnt, 1);
    chk("ctr_brick_cleared", int'(mem[105]), 0);

    init_map();
    run(2'b10, 0, 21);
    chk("corner_ack_who", int'(acks[0]), 2);
    chk("corner_ack_once", acks.size(), 1);
    chk("corner_ack_cycle", ack_cyc, 8);
    chk("corner_read_1", int'(seen[1]), 1);
    chk("corner_read_20", int'(seen[20]), 1);
    chk("corner_writes", nwr, 0);
    chk("corner_walls_kept", int'({mem[1], mem[20]}), 9);

    init_map();
    mem[125] = 3'd3;
    mem[106] = 3'd4;
    run(2'b01, 105, 0);
    chk("base0_pulses", bh0, 1);
    chk("base1_pulses", bh1, 1);
    chk("base_tiles_kept", int'({mem[125], mem[106]}), 28);
    chk("base_145_unread", int'(seen[145]), 0);
    chk("base_107_unread", int'(seen[107]), 0);
    chk("base_writes", nwr, 0);
    chk("base_ack_cycle", ack_cyc, 8);

    run(2'b01, 300, 0);
    chk("oob_ack_cycle", ack_cyc, 1);
    chk("oob_err", errv, 1);
    chk("oob_writes", nwr, 0);
    chk("oob_rd_held", rdlog[1], 106);

    init_map();
    mem[85] = 3'd2;
    req_idx0 = 9'd105;
    req = 2'b01;
    repeat (3) @(negedge clk);
    chk("mid_wr_en_before", int'(wr_en), 1);
    chk("mid_wr_idx_before", int'(wr_idx), 85);
    #1;
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("mid_wr_en_reset", int'(wr_en), 0);
    chk("mid_busy_reset", int'(busy), 0);
    chk("mid_ack_reset", int'(ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack != 2'b00) nack++;
    end
    chk("mid_no_ack", nack, 0);
    chk("mid_brick_kept", int'(mem[85]), 2);

    run(2'b11, 105, 27);
    chk("both_first", int'(acks[0]), 1);
    chk("both_second", int'(acks[1]), 2);
    chk("both_cnt_p0", cnt, 1);
    chk("both_err", errv, 0);
    chk("both_writes", nwr, 1);
    chk("both_no_wr_ack", wr_ack, 0);
    run(2'b11, 105, 27);
    chk("rr_after_p1", int'(acks[0]), 1);
    run(2'b01, 105, 0);
    run(2'b11, 105, 27);
    chk("rr_after_p0", int'(acks[0]), 2);
    chk("rr_after_p0_second", int'(acks[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
